// File: rtl/build_wr_data_packer_pkg.sv
`default_nettype none
// ============================================================================
// build_wr_data_packer_pkg
// Shared pixel/beat geometry for the DDR write-path packer.
// Revision: 1.0  initial release
// ============================================================================
package build_wr_data_packer_pkg;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 128;
    localparam int NWORDS = OUT_W / IN_W;
    localparam int IDX_W  = $clog2(NWORDS);

    typedef logic [IN_W-1:0] pixel_t;

endpackage : build_wr_data_packer_pkg
`default_nettype wire

// File: rtl/build_wr_data_packer.sv
`default_nettype none
// ============================================================================
// build_wr_data_packer
// Packs 16-bit pixels into 128-bit beats; tuser_out flags the first beat of a frame.
// Revision: 1.0  initial release
// ============================================================================
module build_wr_data_packer
    import build_wr_data_packer_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  pixel_t           data_in,
    input  logic             newframe_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [OUT_W-1:0] data_out,
    output logic             tuser_out
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NWORDS - 1);

    logic [IDX_W-1:0]             r_idx;
    logic                         r_frame;
    logic [NWORDS-2:0][IN_W-1:0]  r_acc;
    logic                         r_valid;
    logic [OUT_W-1:0]             r_data;
    logic                         r_tuser;

    logic w_accept;
    logic w_load;

    // Only the final word of a beat can collide with a beat still held downstream.
    assign ready_in = !(r_valid && !ready_out && (r_idx == C_LAST_IDX));
    assign w_accept = valid_in && ready_in;
    assign w_load   = w_accept && !newframe_in && (r_idx == C_LAST_IDX);

    // Index counter, frame flag and accumulator.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_idx   <= '0;
            r_frame <= 1'b0;
            r_acc   <= '0;
        end else if (w_accept) begin
            if (newframe_in || (r_idx == '0)) begin
                // A frame start restarts the beat; any partial beat is dropped.
                r_acc[0] <= data_in;
                r_frame  <= newframe_in;
                r_idx    <= IDX_W'(1);
            end else if (r_idx == C_LAST_IDX) begin
                r_idx <= '0;
            end else begin
                r_acc[r_idx] <= data_in;
                r_idx        <= r_idx + 1'b1;
            end
        end
    end

    // Output register and downstream handshake; a fresh load beats a clear.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tuser <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= {data_in, r_acc};
            r_tuser <= r_frame;
        end else if (r_valid && ready_out) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign tuser_out = r_tuser;

endmodule : build_wr_data_packer
`default_nettype wire

// File: tb/tb_build_wr_data_packer.sv
`default_nettype none
// ============================================================================
// tb_build_wr_data_packer
// Table-driven and scoreboard-checked bench for build_wr_data_packer.
// Revision: 1.0  initial release
// ============================================================================
module tb_build_wr_data_packer;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         valid_in;
    logic         ready_in;
    logic [15:0]  data_in;
    logic         newframe_in;
    logic         valid_out;
    logic         ready_out;
    logic [127:0] data_out;
    logic         tuser_out;

    build_wr_data_packer dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_in     (data_in),
        .newframe_in (newframe_in),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .tuser_out   (tuser_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [7:0][15:0] w;
        logic             nf0;
        logic [127:0]     exp_data;
        logic             exp_tuser;
    } vec_t;

    typedef struct packed {
        logic [127:0] d;
        logic         u;
    } beat_t;

    vec_t  tbl [5];
    beat_t sb [$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed downstream transfer must match the oldest expectation.
    always @(negedge clk_in) begin
        if (!rst_in && valid_out && ready_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got beat %h expected none", data_out);
            end else begin
                mon_e = sb.pop_front();
                check("sb_data", data_out, mon_e.d);
                check("sb_tuser", 128'(tuser_out), 128'(mon_e.u));
            end
        end
    end

    task automatic send_word(input logic [15:0] d, input logic nf, input int gap);
        int n;
        n           = 0;
        valid_in    = 1'b1;
        data_in     = d;
        newframe_in = nf;
        @(negedge clk_in);
        while (!ready_in && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        if (!ready_in) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready_in=0 expected 1 for word %h", d);
        end
        @(posedge clk_in);
        #1;
        valid_in    = 1'b0;
        newframe_in = 1'b0;
        repeat (gap) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic run_vec(input int i, input int gap);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) sb.push_back({tbl[i].exp_data, tbl[i].exp_tuser});
            send_word(tbl[i].w[k], (k == 0) ? tbl[i].nf0 : 1'b0, (k == 7) ? 0 : gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t4 [11];

        tbl[0].w = {16'hBEEF, 16'hDEAD, 16'h3210, 16'h7654,
                    16'h5678, 16'h1234, 16'hDCBA, 16'hABCD};
        tbl[0].nf0       = 1'b1;
        tbl[0].exp_data  = 128'hBEEF_DEAD_3210_7654_5678_1234_DCBA_ABCD;
        tbl[0].exp_tuser = 1'b1;
        for (int k = 0; k < 8; k++) tbl[1].w[k] = 16'(k + 1);
        tbl[1].nf0       = 1'b0;
        tbl[1].exp_data  = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        tbl[1].exp_tuser = 1'b0;
        for (int k = 0; k < 8; k++) tbl[2].w[k] = 16'(16'hA000 + k);
        tbl[2].nf0       = 1'b1;
        tbl[2].exp_data  = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
        tbl[2].exp_tuser = 1'b1;
        for (int k = 0; k < 8; k++) tbl[3].w[k] = 16'(16'hB000 + k);
        tbl[3].nf0       = 1'b0;
        tbl[3].exp_data  = 128'hB007_B006_B005_B004_B003_B002_B001_B000;
        tbl[3].exp_tuser = 1'b0;
        for (int k = 0; k < 8; k++) tbl[4].w[k] = 16'(16'hC000 + k);
        tbl[4].nf0       = 1'b1;
        tbl[4].exp_data  = 128'hC007_C006_C005_C004_C003_C002_C001_C000;
        tbl[4].exp_tuser = 1'b1;

        rst_in = 1'b1; valid_in = 1'b0; data_in = '0; newframe_in = 1'b0; ready_out = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        #1;
        check("rst_valid", 128'(valid_out), 128'd0);
        check("rst_data", data_out, 128'd0);
        check("rst_tuser", 128'(tuser_out), 128'd0);
        check("rst_ready_in", 128'(ready_in), 128'd1);

        // Single beats, spaced input, free-flowing output.
        for (int i = 0; i < 2; i++) begin
            run_vec(i, 3);
            check("vec_valid_hi", 128'(valid_out), 128'd1);
            check("vec_data", data_out, tbl[i].exp_data);
            check("vec_tuser", 128'(tuser_out), 128'(tbl[i].exp_tuser));
            @(posedge clk_in); #1;
            check("vec_valid_lo", 128'(valid_out), 128'd0);
            check("vec_data_kept", data_out, tbl[i].exp_data);
        end

        // Backpressure: beat held, next words still accepted.
        ready_out = 1'b0;
        run_vec(2, 0);
        repeat (3) begin @(posedge clk_in); #1; end
        check("bp_hold_valid", 128'(valid_out), 128'd1);
        check("bp_hold_data", data_out, tbl[2].exp_data);
        check("bp_ready_in", 128'(ready_in), 128'd1);
        send_word(16'hFFFF, 1'b0, 0);
        send_word(16'hEEEE, 1'b0, 0);
        check("bp_hold_data2", data_out, tbl[2].exp_data);
        ready_out = 1'b1;
        @(posedge clk_in); #1;
        check("bp_released", 128'(valid_out), 128'd0);
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) sb.push_back({128'h1006_1005_1004_1003_1002_1001_EEEE_FFFF, 1'b0});
            send_word(16'(16'h1000 + k), 1'b0, 0);
        end
        repeat (2) begin @(posedge clk_in); #1; end

        // Mid-beat newframe discards the partial beat.
        t4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666,
               16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB};
        sb.push_back({128'hBBBB_AAAA_9999_8888_7777_6666_5555_4444, 1'b1});
        for (int k = 0; k < 11; k++) send_word(t4[k], (k == 3), 1);
        repeat (3) begin @(posedge clk_in); #1; end
        check("nf_data", data_out, 128'hBBBB_AAAA_9999_8888_7777_6666_5555_4444);

        // Stall at the last word: downstream release loads the next beat in the same cycle.
        ready_out = 1'b0;
        run_vec(2, 0);
        for (int k = 0; k < 7; k++) send_word(tbl[3].w[k], 1'b0, 0);
        check("stall_ready_lo", 128'(ready_in), 128'd0);
        sb.push_back({tbl[3].exp_data, tbl[3].exp_tuser});
        valid_in = 1'b1; data_in = tbl[3].w[7]; newframe_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            check("stall_ready_held", 128'(ready_in), 128'd0);
        end
        @(posedge clk_in); #1;
        check("stall_data_a", data_out, tbl[2].exp_data);
        ready_out = 1'b1;
        @(negedge clk_in);
        check("stall_ready_hi", 128'(ready_in), 128'd1);
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        check("stall_valid_kept", 128'(valid_out), 128'd1);
        check("stall_data_b", data_out, tbl[3].exp_data);
        check("stall_tuser_b", 128'(tuser_out), 128'd0);
        @(posedge clk_in); #1;
        check("stall_valid_lo", 128'(valid_out), 128'd0);

        // Asynchronous reset mid-beat with a held output.
        ready_out = 1'b0;
        run_vec(2, 0);
        for (int k = 0; k < 5; k++) send_word(16'(16'hD000 + k), (k == 0), 0);
        rst_in = 1'b1;
        #1;
        check("arst_valid", 128'(valid_out), 128'd0);
        check("arst_data", data_out, 128'd0);
        check("arst_tuser", 128'(tuser_out), 128'd0);
        sb.delete();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        ready_out = 1'b1;
        run_vec(4, 1);
        check("post_rst_data", data_out, tbl[4].exp_data);
        check("post_rst_tuser", 128'(tuser_out), 128'd1);

        repeat (5) begin @(posedge clk_in); #1; end
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_build_wr_data_packer
`default_nettype wire
